// File: rtl/exu_wbck_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exu_wbck_arb_pkg
// Description : Shared widths and writeback-source encodings for the EXU
//               writeback arbiter.
//               XLEN         - register data width
//               RFIDX_WIDTH  - register index width
//               WBCK_SRC_*   - encoding of rf_wbck_o_src
// Revision    : 1.0 - initial release
// ============================================================================
package exu_wbck_arb_pkg;

    localparam int XLEN        = 32;
    localparam int RFIDX_WIDTH = 5;

    localparam logic WBCK_SRC_ALU = 1'b0;
    localparam logic WBCK_SRC_LSU = 1'b1;

    typedef logic [XLEN-1:0]        xlen_t;
    typedef logic [RFIDX_WIDTH-1:0] rfidx_t;

    // Index 0 is the hard-wired zero register; writes to it are discarded.
    function automatic logic is_x0(input rfidx_t idx);
        return (idx == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/exu_wbck_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : exu_wbck_arb_if
// Description : Bundle of the ALU and LSU writeback request channels and the
//               registered regfile write port.
//               master - requester/regfile side (drives valids and data)
//               slave  - arbiter side (drives readies and rf_wbck_o_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface exu_wbck_arb_if;
    import exu_wbck_arb_pkg::*;

    logic   alu_wbck_i_valid;
    logic   alu_wbck_i_ready;
    xlen_t  alu_wbck_i_wdat;
    rfidx_t alu_wbck_i_rdidx;

    logic   lsu_wbck_i_valid;
    logic   lsu_wbck_i_ready;
    xlen_t  lsu_wbck_i_wdat;
    rfidx_t lsu_wbck_i_rdidx;

    logic   rf_wbck_o_ena;
    xlen_t  rf_wbck_o_wdat;
    rfidx_t rf_wbck_o_rdidx;
    logic   rf_wbck_o_src;

    modport master (
        output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
        output lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_rdidx,
        input  alu_wbck_i_ready, lsu_wbck_i_ready,
        input  rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx, rf_wbck_o_src
    );

    modport slave (
        input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
        input  lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_rdidx,
        output alu_wbck_i_ready, lsu_wbck_i_ready,
        output rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx, rf_wbck_o_src
    );

endinterface
`default_nettype wire

// File: rtl/exu_wbck_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : exu_wbck_pick
// Description : Two-input priority picker. The LSU wins a contended cycle
//               unless alu_promote is set. Grants are one-hot or zero and
//               never issued to an invalid requester.
//               lsu_valid/alu_valid - requests
//               alu_promote         - ALU has been starved long enough
//               lsu_grant/alu_grant - one-hot grants
// Revision    : 1.0 - initial release
// ============================================================================
module exu_wbck_pick (
    input  logic lsu_valid,
    input  logic alu_valid,
    input  logic alu_promote,
    output logic lsu_grant,
    output logic alu_grant
);

    always_comb begin
        alu_grant = alu_valid & (~lsu_valid | alu_promote);
        lsu_grant = lsu_valid & ~(alu_valid & alu_promote);
    end

endmodule
`default_nettype wire

// File: rtl/exu_wbck_arb.sv
`default_nettype none
// ============================================================================
// Module      : exu_wbck_arb
// Description : Shares the single regfile write port between the ALU and the
//               LSU. LSU has priority; an ALU denied STARVE_MAX consecutive
//               cycles is promoted over the LSU. The write command is
//               registered (one-cycle ena pulse per accept); x0 writes are
//               consumed but never reach the regfile.
//               clk   - core clock
//               rst_n - asynchronous active-low reset
//               wb    - request channels and regfile port (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module exu_wbck_arb
    import exu_wbck_arb_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    exu_wbck_arb_if.slave      wb
);

    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_ena;
    xlen_t            r_wdat;
    rfidx_t           r_rdidx;
    logic             r_src;

    logic             w_alu_promote;
    logic             w_alu_grant;
    logic             w_lsu_grant;
    logic             w_accept;
    xlen_t            w_wdat;
    rfidx_t           w_rdidx;
    logic             w_write;

    assign w_alu_promote = (r_starve_cnt == c_starve_max);

    exu_wbck_pick u_pick (
        .lsu_valid   (wb.lsu_wbck_i_valid),
        .alu_valid   (wb.alu_wbck_i_valid),
        .alu_promote (w_alu_promote),
        .lsu_grant   (w_lsu_grant),
        .alu_grant   (w_alu_grant)
    );

    // Regfile never stalls, so a grant is a completed handshake.
    assign wb.alu_wbck_i_ready = w_alu_grant;
    assign wb.lsu_wbck_i_ready = w_lsu_grant;

    // Grants are only issued to valid requesters.
    assign w_accept = w_alu_grant | w_lsu_grant;
    assign w_wdat   = w_lsu_grant ? wb.lsu_wbck_i_wdat  : wb.alu_wbck_i_wdat;
    assign w_rdidx  = w_lsu_grant ? wb.lsu_wbck_i_rdidx : wb.alu_wbck_i_rdidx;
    assign w_write  = w_accept & ~is_x0(w_rdidx);

    // Counts consecutive cycles the ALU was waiting but lost; any cycle in
    // which it is either served or idle restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (wb.alu_wbck_i_valid && !w_alu_grant) begin
            if (r_starve_cnt != c_starve_max) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // Data registers only move on a real (non-x0) write so the regfile port
    // keeps showing the last committed write between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ena   <= 1'b0;
            r_wdat  <= '0;
            r_rdidx <= '0;
            r_src   <= WBCK_SRC_ALU;
        end else begin
            r_ena <= w_write;
            if (w_write) begin
                r_wdat  <= w_wdat;
                r_rdidx <= w_rdidx;
                r_src   <= w_lsu_grant ? WBCK_SRC_LSU : WBCK_SRC_ALU;
            end
        end
    end

    assign wb.rf_wbck_o_ena   = r_ena;
    assign wb.rf_wbck_o_wdat  = r_wdat;
    assign wb.rf_wbck_o_rdidx = r_rdidx;
    assign wb.rf_wbck_o_src   = r_src;

endmodule
`default_nettype wire

// File: tb/tb_exu_wbck_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_exu_wbck_arb
// Description : Self-checking bench for exu_wbck_arb. A behavioural model
//               (denial counter + last-committed-write record) predicts the
//               readies and the registered regfile port every cycle; directed
//               scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exu_wbck_arb;
    import exu_wbck_arb_pkg::*;

    localparam int STARVE_MAX = 3;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_tot;

    exu_wbck_arb_if wb ();

    exu_wbck_arb #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int     m_denied;   // consecutive cycles the ALU waited and lost
    logic   m_ena;
    xlen_t  m_wdat;
    rfidx_t m_rdidx;
    logic   m_src;

    function automatic logic model_alu_wins();
        if (!wb.alu_wbck_i_valid) return 1'b0;
        if (!wb.lsu_wbck_i_valid) return 1'b1;
        return (m_denied >= STARVE_MAX);
    endfunction

    function automatic logic model_lsu_wins();
        return wb.lsu_wbck_i_valid && !model_alu_wins();
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        logic   aw, lw;
        rfidx_t rd;
        if (!rst_n) begin
            m_denied <= 0;
            m_ena    <= 1'b0;
            m_wdat   <= '0;
            m_rdidx  <= '0;
            m_src    <= 1'b0;
        end else begin
            aw = model_alu_wins();
            lw = model_lsu_wins();
            m_denied <= (wb.alu_wbck_i_valid && !aw) ? m_denied + 1 : 0;
            rd = lw ? wb.lsu_wbck_i_rdidx : wb.alu_wbck_i_rdidx;
            if ((aw || lw) && rd != 0) begin
                m_ena   <= 1'b1;
                m_rdidx <= rd;
                m_wdat  <= lw ? wb.lsu_wbck_i_wdat : wb.alu_wbck_i_wdat;
                m_src   <= lw;
            end else begin
                m_ena <= 1'b0;
            end
        end
    end

    // Every out-of-reset cycle: readies and the regfile port vs the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("alu_ready", {63'd0, wb.alu_wbck_i_ready}, {63'd0, model_alu_wins()});
            chk("lsu_ready", {63'd0, wb.lsu_wbck_i_ready}, {63'd0, model_lsu_wins()});
            chk("rf_ena",    {63'd0, wb.rf_wbck_o_ena},    {63'd0, m_ena});
            chk("rf_wdat",   64'(wb.rf_wbck_o_wdat),       64'(m_wdat));
            chk("rf_rdidx",  64'(wb.rf_wbck_o_rdidx),      64'(m_rdidx));
            chk("rf_src",    {63'd0, wb.rf_wbck_o_src},    {63'd0, m_src});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic av, input xlen_t ad, input rfidx_t ar,
                         input logic lv, input xlen_t ld, input rfidx_t lr);
        wb.alu_wbck_i_valid = av;
        wb.alu_wbck_i_wdat  = ad;
        wb.alu_wbck_i_rdidx = ar;
        wb.lsu_wbck_i_valid = lv;
        wb.lsu_wbck_i_wdat  = ld;
        wb.lsu_wbck_i_rdidx = lr;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic ena, input xlen_t wd,
                           input rfidx_t rd, input logic src);
        chk({name, "_ena"},   {63'd0, wb.rf_wbck_o_ena},  {63'd0, ena});
        chk({name, "_wdat"},  64'(wb.rf_wbck_o_wdat),     64'(wd));
        chk({name, "_rdidx"}, 64'(wb.rf_wbck_o_rdidx),    64'(rd));
        chk({name, "_src"},   {63'd0, wb.rf_wbck_o_src},  {63'd0, src});
    endtask

    logic exp_alu_gnt [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        n_pass = 0;
        n_tot  = 0;
        rst_n  = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #3;
        chk_out("reset", 1'b0, 32'h0, 5'd0, 1'b0);
        rst_n = 1'b1;
        step();

        // ALU only, rd=5
        drive(1'b1, 32'h1234, 5'd5, 1'b0, '0, '0);
        @(negedge clk);
        chk("alu_only_ready", {63'd0, wb.alu_wbck_i_ready}, 64'd1);
        step();
        chk_out("alu_only", 1'b1, 32'h1234, 5'd5, 1'b0);
        idle();
        step();

        // Continuous contention: L,L,L,A,L,L,L,A
        drive(1'b1, 32'hBBBB, 5'd9, 1'b1, 32'hAAAA, 5'd7);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("contend_alu_gnt", {63'd0, wb.alu_wbck_i_ready}, {63'd0, exp_alu_gnt[i]});
            chk("contend_lsu_gnt", {63'd0, wb.lsu_wbck_i_ready}, {63'd0, !exp_alu_gnt[i]});
            if (i > 0) chk("contend_ena", {63'd0, wb.rf_wbck_o_ena}, 64'd1);
        end
        step();
        chk_out("contend_last", 1'b1, 32'hBBBB, 5'd9, 1'b0);
        idle();
        step();

        // x0 write is consumed but leaves the port untouched
        drive(1'b1, 32'h55, 5'd3, 1'b0, '0, '0);
        step();
        drive(1'b1, 32'hFFFF_FFFF, 5'd0, 1'b0, '0, '0);
        @(negedge clk);
        chk("x0_ready", {63'd0, wb.alu_wbck_i_ready}, 64'd1);
        step();
        chk_out("x0", 1'b0, 32'h55, 5'd3, 1'b0);
        idle();
        step();

        // Two denials, then LSU drops: ALU served, count restarts
        drive(1'b1, 32'h11, 5'd1, 1'b1, 32'h22, 5'd2);
        step();
        step();
        drive(1'b1, 32'h11, 5'd1, 1'b0, '0, '0);
        @(negedge clk);
        chk("drop_alu_gnt", {63'd0, wb.alu_wbck_i_ready}, 64'd1);
        step();
        drive(1'b1, 32'h11, 5'd1, 1'b1, 32'h22, 5'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fresh_alu_gnt", {63'd0, wb.alu_wbck_i_ready}, {63'd0, exp_alu_gnt[i]});
        end
        step();
        idle();
        step();

        // Reset in the cycle after an LSU accept
        drive(1'b0, '0, '0, 1'b1, 32'h77, 5'd4);
        step();
        idle();
        chk("pre_reset_ena", {63'd0, wb.rf_wbck_o_ena}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_out("mid_reset", 1'b0, 32'h0, 5'd0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        drive(1'b0, '0, '0, 1'b1, 32'h88, 5'd6);
        @(negedge clk);
        chk("post_reset_lsu_gnt", {63'd0, wb.lsu_wbck_i_ready}, 64'd1);
        step();
        chk_out("post_reset", 1'b1, 32'h88, 5'd6, 1'b1);

        // Idle for 4 cycles: outputs hold
        idle();
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_alu_rdy", {63'd0, wb.alu_wbck_i_ready}, 64'd0);
            chk("idle_lsu_rdy", {63'd0, wb.lsu_wbck_i_ready}, 64'd0);
            chk_out("idle", 1'b0, 32'h88, 5'd6, 1'b1);
        end
        step();

        // Random traffic, one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                #1 rst_n = 1'b0;
                @(posedge clk);
                #3 rst_n = 1'b1;
                step();
            end
            drive($urandom_range(0, 3) != 0, xlen_t'($urandom),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : rfidx_t'($urandom_range(1, 31)),
                  $urandom_range(0, 2) != 0, xlen_t'($urandom),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : rfidx_t'($urandom_range(1, 31)));
            step();
        end
        idle();
        step();
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
